// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: load-use, branch, memory-wait and multiply/divide-wait handling.
// Optional stall cycle counter is enabled by defining STALL_CNT_EN.
module pipe_stall_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lu_hazard,
    input  logic             br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             mdu_start,
    input  logic             mdu_done,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             stall_idex,
    output logic             stall_exmem,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic             bubble_memwb,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] RUN      = 2'b00;
    localparam logic [1:0] MEM_WAIT = 2'b01;
    localparam logic [1:0] MDU_WAIT = 2'b10;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       mdu_pend;
    logic       pend_d;
    logic       mem_miss;
    logic [7:0] ctrl;

    localparam logic [7:0] CTRL_MEM = 8'b1111_0001;
    localparam logic [7:0] CTRL_MDU = 8'b1110_0010;
    localparam logic [7:0] CTRL_BR  = 8'b0000_1100;
    localparam logic [7:0] CTRL_LU  = 8'b1100_0100;

    assign mem_miss = mem_req & ~mem_ready;

    always_comb begin
        ctrl    = 8'b0;
        state_d = RUN;
        pend_d  = mdu_pend;
        case (state_q)
            MEM_WAIT: begin
                // A completion seen during the miss is absorbed here so the exit skips MDU_WAIT.
                if (mdu_done) begin
                    pend_d = 1'b0;
                end
                if (!mem_ready) begin
                    ctrl    = CTRL_MEM;
                    state_d = MEM_WAIT;
                end else begin
                    state_d = pend_d ? MDU_WAIT : RUN;
                end
            end
            MDU_WAIT: begin
                if (mdu_done) begin
                    pend_d  = 1'b0;
                    state_d = RUN;
                end else if (mem_miss) begin
                    ctrl    = CTRL_MEM;
                    state_d = MEM_WAIT;
                end else begin
                    ctrl    = CTRL_MDU;
                    state_d = MDU_WAIT;
                end
            end
            default: begin
                if (mem_miss) begin
                    ctrl    = CTRL_MEM;
                    state_d = MEM_WAIT;
                end else if (mdu_start) begin
                    ctrl    = CTRL_MDU;
                    pend_d  = 1'b1;
                    state_d = MDU_WAIT;
                end else if (br_taken) begin
                    ctrl    = CTRL_BR;
                end else if (lu_hazard) begin
                    ctrl    = CTRL_LU;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            mdu_pend <= 1'b0;
        end else begin
            state_q  <= state_d;
            mdu_pend <= pend_d;
        end
    end

    // Reset masks the combinational controls so nothing leaks out while rst is high.
    assign {stall_pc, stall_ifid, stall_idex, stall_exmem,
            flush_ifid, flush_idex, flush_exmem, bubble_memwb} = rst ? 8'b0 : ctrl;
    assign state = state_q;

`ifdef STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_pc && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed scenarios plus randomized traffic against a flag-based model.
// Build with STALL_CNT_EN defined to also check the saturating counter.
module tb_pipe_stall_ctrl;

    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          lu_hazard, br_taken, mem_req, mem_ready, mdu_start, mdu_done;
    logic          stall_pc, stall_ifid, stall_idex, stall_exmem;
    logic          flush_ifid, flush_idex, flush_exmem, bubble_memwb;
    logic [1:0]    state;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .lu_hazard(lu_hazard), .br_taken(br_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .mdu_start(mdu_start), .mdu_done(mdu_done),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex), .stall_exmem(stall_exmem),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem), .bubble_memwb(bubble_memwb),
        .state(state), .stall_cnt(stall_cnt)
    );

    typedef struct packed {
        logic [1:0]    st;
        logic [7:0]    outs;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    // Model: a memory miss outstanding and/or a multiply/divide outstanding.
    bit memBusy, mduBusy, nextMem, nextMdu;
    int stallTotal, nextTotal;

    localparam logic [7:0] ALL_STALL = 8'b1111_0001;
    localparam logic [7:0] MDU_STALL = 8'b1110_0010;
    localparam logic [7:0] BR_FLUSH  = 8'b0000_1100;
    localparam logic [7:0] LU_STALL  = 8'b1100_0100;

    function automatic logic [7:0] ctrlVec();
        return {stall_pc, stall_ifid, stall_idex, stall_exmem,
                flush_ifid, flush_idex, flush_exmem, bubble_memwb};
    endfunction

    function void checkOutput(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic int expectedCnt(input int total);
`ifdef STALL_CNT_EN
        return (total > CNT_MAX) ? CNT_MAX : total;
`else
        return 0;
`endif
    endfunction

    // Monitor: every sampled cycle has one expected response waiting.
    always @(negedge clk) begin
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("state", state, e.st);
            checkOutput("ctrl", ctrlVec(), e.outs);
            checkOutput("stall_cnt", stall_cnt, e.cnt);
        end
    end

    // s = {lu_hazard, br_taken, mem_req, mem_ready, mdu_start, mdu_done}
    task applyStimulus(input logic [5:0] s);
        logic [7:0] outs;
        bit         nm, nd, miss;
        exp_t       e;
        @(posedge clk);
        #1;
        memBusy    = nextMem;
        mduBusy    = nextMdu;
        stallTotal = nextTotal;
        {lu_hazard, br_taken, mem_req, mem_ready, mdu_start, mdu_done} = s;
        outs = 8'b0;
        nm   = memBusy;
        nd   = mduBusy;
        miss = mem_req && !mem_ready;
        if (memBusy) begin
            if (mdu_done) nd = 1'b0;
            if (!mem_ready) outs = ALL_STALL;
            else nm = 1'b0;
        end else if (mduBusy) begin
            if (mdu_done) nd = 1'b0;
            else if (miss) begin outs = ALL_STALL; nm = 1'b1; end
            else outs = MDU_STALL;
        end else begin
            if (miss) begin outs = ALL_STALL; nm = 1'b1; end
            else if (mdu_start) begin outs = MDU_STALL; nd = 1'b1; end
            else if (br_taken) outs = BR_FLUSH;
            else if (lu_hazard) outs = LU_STALL;
        end
        e.st   = memBusy ? 2'b01 : (mduBusy ? 2'b10 : 2'b00);
        e.outs = outs;
        e.cnt  = CW'(expectedCnt(stallTotal));
        expQ.push_back(e);
        nextMem   = nm;
        nextMdu   = nd;
        nextTotal = stallTotal + (outs[7] ? 1 : 0);
    endtask

    task clearModel();
        memBusy = 0; mduBusy = 0; nextMem = 0; nextMdu = 0;
        stallTotal = 0; nextTotal = 0;
    endtask

    // Async reset in mid-cycle with hazards asserted; outputs must clear without an edge.
    task doReset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        lu_hazard = 1'b1; br_taken = 1'b1; mem_req = 1'b1; mem_ready = 1'b0; mdu_start = 1'b1;
        #1;
        checkOutput("rst_state", state, 0);
        checkOutput("rst_ctrl", ctrlVec(), 0);
        checkOutput("rst_cnt", stall_cnt, 0);
        @(posedge clk);
        #1;
        checkOutput("rst_hold_ctrl", ctrlVec(), 0);
        checkOutput("rst_hold_state", state, 0);
        @(negedge clk);
        #1;
        {lu_hazard, br_taken, mem_req, mem_ready, mdu_start, mdu_done} = 6'b0;
        rst = 1'b0;
        clearModel();
    endtask

    initial begin
        clearModel();
        rst = 1'b1;
        {lu_hazard, br_taken, mem_req, mem_ready, mdu_start, mdu_done} = 6'b100010;
        #12;
        checkOutput("init_state", state, 0);
        checkOutput("init_ctrl", ctrlVec(), 0);
        checkOutput("init_cnt", stall_cnt, 0);
        @(negedge clk);
        {lu_hazard, br_taken, mem_req, mem_ready, mdu_start, mdu_done} = 6'b0;
        rst = 1'b0;

        // Load-use, then branch overriding load-use.
        applyStimulus(6'b100000);
        applyStimulus(6'b000000);
        applyStimulus(6'b110000);
        applyStimulus(6'b000000);
        // Three-cycle memory miss.
        repeat (3) applyStimulus(6'b001000);
        applyStimulus(6'b001100);
        applyStimulus(6'b000000);
        // Nested: mdu, miss two cycles later, mdu_done during the miss.
        applyStimulus(6'b000010);
        applyStimulus(6'b000000);
        applyStimulus(6'b001000);
        applyStimulus(6'b001001);
        applyStimulus(6'b001000);
        applyStimulus(6'b001100);
        applyStimulus(6'b000000);
        applyStimulus(6'b000000);
        // Reset while in MDU_WAIT after several stalls.
        repeat (5) applyStimulus(6'b100000);
        applyStimulus(6'b000010);
        applyStimulus(6'b000000);
        doReset();
        applyStimulus(6'b100000);
        applyStimulus(6'b000000);
        // Saturation run.
        repeat (20) applyStimulus(6'b100000);
        applyStimulus(6'b000000);

        for (int i = 0; i < 400; i++) begin
            logic [5:0] s;
            s[5] = ($urandom_range(0, 99) < 30);
            s[4] = ($urandom_range(0, 99) < 20);
            s[3] = ($urandom_range(0, 99) < 30);
            s[2] = ($urandom_range(0, 99) < 60);
            s[1] = ($urandom_range(0, 99) < 15);
            s[0] = ($urandom_range(0, 99) < 25);
            applyStimulus(s);
            if ((i % 100) == 99) doReset();
        end

        @(negedge clk);
        #1;
        if (expQ.size() != 0) checkOutput("queue_drain", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
